board_top: RTL and testbench
============================

BOARD_TOP -- requirements
Module: board_top

Interface
REQ-001 SHALL have port clk_i, input, 1 bit: single system clock, 50 MHz (20 ns period); all logic in this one domain.
REQ-002 SHALL have port rst_n_i, input, 1 bit: reset, synchronous and active-low.
REQ-003 SHALL have port vga_hs_o, output, 1 bit: VGA horizontal sync, active low.
REQ-004 SHALL have port vga_vs_o, output, 1 bit: VGA vertical sync, active low.
REQ-005 SHALL have ports vga_r_o, vga_g_o, vga_b_o, output, 4 bits each: pixel colour, driven only in the visible area.
REQ-006 SHALL have no other ports, and all outputs SHALL be registered.

Function
REQ-007 SHALL have an internal pixel-enable register pix_en that resets to 0 and toggles every clk_i edge, giving a 25 MHz tick.
REQ-008 SHALL have hcnt (10 bits, 0..799) that advances only on cycles with pix_en=1 and wraps 799->0.
REQ-009 SHALL have vcnt (10 bits, 0..524) that advances when hcnt wraps and wraps 524->0.
REQ-010 SHALL use horizontal timing of 640 visible, 16 front porch, 96 sync (hcnt 656..751), 48 back porch.
REQ-011 SHALL use vertical timing of 480 visible, 10 front porch, 2 sync (vcnt 490..491), 33 back porch.
REQ-012 SHALL register vga_hs_o and vga_vs_o one clk_i after counter decode: low exactly while the decoded counter lies in its sync range.
REQ-013 SHALL give a line period of 1600 clk_i, hs low for 192 clk_i, a frame of 840000 clk_i, and vs low for 3200 clk_i.
REQ-014 SHALL define the visible area as hcnt<640 and vcnt<480; outside it all colour outputs SHALL be 0.
REQ-015 SHALL keep game state in pixel coordinates: ball 8x8 (ball_x, ball_y, dx, dy); left paddle at x=16 and right paddle at x=616, each 8 wide and 64 tall, with y positions pl_y and pr_y.
REQ-016 SHALL update game state once per frame, on the pix_en cycle where hcnt=0 and vcnt=480 (start of vblank).
REQ-017 SHALL move the ball by dx, dy with |dx|=|dy|=2 px/frame.
REQ-018 SHALL negate dy when the next ball_y would be <0 or >472, and clamp ball_y to that range.
REQ-019 SHALL bounce off a paddle by setting dx positive (left paddle) or negative (right paddle) when the ball box overlaps the paddle box after moving.
REQ-020 SHALL treat a ball reaching x<=0 as a right-player point and x>=632 as a left-player point.
REQ-021 SHALL, on a point, increment the scorer's score (4 bits) and put the ball at (316,236) with dx toward the player who lost the point.
REQ-022 SHALL reset both scores to 0 when a score would exceed 9.
REQ-023 SHALL drive each paddle by AI: move 2 px/frame toward ball_y-28, no move if within 2 px, y clamped to 0..416.
REQ-024 SHALL colour pixels by priority: ball or paddle pixel gives white (F,F,F); centre line (hcnt 318..321 and vcnt[4]=0) gives grey (8,8,8); else black.
REQ-025 SHALL register colour outputs with the same one-clk latency as the syncs so that the colour, hs and vs outputs stay aligned.

Reset
REQ-026 SHALL, while rst_n_i=0 at a clk_i edge, clear pix_en, hcnt, vcnt and scores to 0, and drive vga_hs_o=1, vga_vs_o=1 and colour outputs to 0.
REQ-027 SHALL, on the same reset, set ball to (316,236) with dx=+2, dy=+2, and set pl_y=pr_y=208.
REQ-028 SHALL apply reset asserted mid-line or mid-frame on the next edge, restarting timing from hcnt=vcnt=0.
REQ-029 SHALL number edges after reset release from edge 1 (first edge with rst_n_i=1); pix_en=1 after odd edges, and hcnt=k after edge 2k.

Verification
REQ-030 SHALL pass: reset held 2 edges, then released -> vga_hs_o falls at edge 1313 and rises at edge 1505.
REQ-031 SHALL pass: free run of 10000 cycles -> hs falling edges every 1600 clk_i, each low 192 clk_i; vga_vs_o stays 1 throughout.
REQ-032 SHALL pass: run one full frame -> vga_vs_o low for edges where vcnt is 490..491, 3200 clk_i, repeating every 840000 clk_i.
REQ-033 SHALL pass: reset asserted at hcnt=700 -> next edge hs=1, vs=1, colour 0, and counters restart from 0.
REQ-034 SHALL pass: first frame after reset -> white pixels at ball (316..323, 236..243) and paddle columns 16..23/616..623 for rows 208..271; colour 0 at hcnt>=640.
REQ-035 SHALL pass: ball forced toward the top edge with a fixed dy -> dy sign flips and ball_y never leaves 0..472.

Source files
------------

// File: rtl/board_top.sv
`default_nettype none
// ============================================================================
// Module   : board_top
// Purpose  : 640x480@60 VGA timing plus a self-playing pong game. Both paddles
//            are AI-driven, the ball bounces off the walls and paddles, and
//            the score wraps after 9. Every output is registered.
// Revision : 1.0 - initial release
// ============================================================================
module board_top (
  input  logic       clk_i,
  input  logic       rst_n_i,
  output logic       vga_hs_o,
  output logic       vga_vs_o,
  output logic [3:0] vga_r_o,
  output logic [3:0] vga_g_o,
  output logic [3:0] vga_b_o
);

  // Raster geometry
  localparam logic [9:0] c_H_LAST   = 10'd799;
  localparam logic [9:0] c_V_LAST   = 10'd524;
  localparam logic [9:0] c_H_VIS    = 10'd640;
  localparam logic [9:0] c_V_VIS    = 10'd480;
  localparam logic [9:0] c_HS_BEG   = 10'd656;
  localparam logic [9:0] c_HS_END   = 10'd751;
  localparam logic [9:0] c_VS_BEG   = 10'd490;
  localparam logic [9:0] c_VS_END   = 10'd491;

  // Playfield objects
  localparam logic [9:0] c_BALL_X0  = 10'd316;
  localparam logic [9:0] c_BALL_Y0  = 10'd236;
  localparam logic [9:0] c_PAD_Y0   = 10'd208;
  localparam logic [9:0] c_PL_X     = 10'd16;
  localparam logic [9:0] c_PR_X     = 10'd616;
  localparam logic [9:0] c_BALL_SZ  = 10'd8;
  localparam logic [9:0] c_PAD_W    = 10'd8;
  localparam logic [9:0] c_PAD_H    = 10'd64;

  // Raster counters
  logic       r_pix_en;
  logic [9:0] r_hcnt;
  logic [9:0] r_vcnt;

  // Game state
  logic [9:0] r_ball_x;
  logic [9:0] r_ball_y;
  logic       r_dx_neg;
  logic       r_dy_neg;
  logic [9:0] r_pl_y;
  logic [9:0] r_pr_y;
  logic [3:0] r_score_l;
  logic [3:0] r_score_r;

  // Next-frame game state (signed so under/overflow of the playfield is visible)
  logic signed [11:0] w_nx;
  logic signed [11:0] w_ny;
  logic signed [11:0] w_nyc;
  logic signed [11:0] w_tgt;
  logic signed [11:0] w_pl_s;
  logic signed [11:0] w_pr_s;
  logic               w_hit_l;
  logic               w_hit_r;
  logic               w_pt_l;
  logic               w_pt_r;
  logic [9:0]         w_bx_nxt;
  logic [9:0]         w_by_nxt;
  logic               w_dxn_nxt;
  logic               w_dyn_nxt;
  logic [9:0]         w_pl_nxt;
  logic [9:0]         w_pr_nxt;
  logic [3:0]         w_sl_nxt;
  logic [3:0]         w_sr_nxt;
  logic               w_frame;

  // Pixel decode
  logic        w_vis;
  logic        w_ball;
  logic        w_pad;
  logic        w_mid;
  logic        w_hs;
  logic        w_vs;
  logic [11:0] w_rgb;

  // One AI paddle step: chase the target by 2 px, dead band of +/-2 px,
  // then keep the paddle fully on screen.
  function automatic logic [9:0] ai_step(input logic [9:0] p, input logic signed [11:0] tgt);
    logic signed [11:0] ps;
    logic signed [11:0] diff;
    logic signed [11:0] np;
    ps   = signed'({2'b00, p});
    diff = tgt - ps;
    np   = ps;
    if (diff > 12'sd2)
      np = ps + 12'sd2;
    else if (diff < -12'sd2)
      np = ps - 12'sd2;
    if (np < 12'sd0)
      np = 12'sd0;
    else if (np > 12'sd416)
      np = 12'sd416;
    return np[9:0];
  endfunction

  // 25 MHz pixel tick and the 800x525 raster counters
  always_ff @(posedge clk_i) begin
    if (!rst_n_i) begin
      r_pix_en <= 1'b0;
      r_hcnt   <= 10'd0;
      r_vcnt   <= 10'd0;
    end else begin
      r_pix_en <= ~r_pix_en;
      if (r_pix_en) begin
        if (r_hcnt == c_H_LAST) begin
          r_hcnt <= 10'd0;
          r_vcnt <= (r_vcnt == c_V_LAST) ? 10'd0 : r_vcnt + 10'd1;
        end else begin
          r_hcnt <= r_hcnt + 10'd1;
        end
      end
    end
  end

  // Game update fires once per frame, at the first pixel of vertical blanking
  assign w_frame = r_pix_en && (r_hcnt == 10'd0) && (r_vcnt == c_V_VIS);

  // Next game state: move ball, wall bounce, paddle bounce, scoring, paddle AI
  always_comb begin
    w_nx      = signed'({2'b00, r_ball_x}) + (r_dx_neg ? -12'sd2 : 12'sd2);
    w_ny      = signed'({2'b00, r_ball_y}) + (r_dy_neg ? -12'sd2 : 12'sd2);
    w_nyc     = w_ny;
    w_dyn_nxt = r_dy_neg;
    if (w_ny < 12'sd0) begin
      w_nyc     = 12'sd0;
      w_dyn_nxt = ~r_dy_neg;
    end else if (w_ny > 12'sd472) begin
      w_nyc     = 12'sd472;
      w_dyn_nxt = ~r_dy_neg;
    end

    // Box overlap after the move; x ranges fold in the 8 px ball width
    w_pl_s  = signed'({2'b00, r_pl_y});
    w_pr_s  = signed'({2'b00, r_pr_y});
    w_hit_l = (w_nx >= 12'sd9)   && (w_nx <= 12'sd23) &&
              (w_nyc + 12'sd7 >= w_pl_s) && (w_nyc <= w_pl_s + 12'sd63);
    w_hit_r = (w_nx >= 12'sd609) && (w_nx <= 12'sd623) &&
              (w_nyc + 12'sd7 >= w_pr_s) && (w_nyc <= w_pr_s + 12'sd63);
    w_pt_r  = (w_nx <= 12'sd0);
    w_pt_l  = (w_nx >= 12'sd632);

    w_dxn_nxt = r_dx_neg;
    if (w_hit_l)
      w_dxn_nxt = 1'b0;
    if (w_hit_r)
      w_dxn_nxt = 1'b1;

    w_bx_nxt = w_nx[9:0];
    w_by_nxt = w_nyc[9:0];
    w_sl_nxt = r_score_l;
    w_sr_nxt = r_score_r;
    // On a point the ball restarts in the centre heading to the loser
    if (w_pt_r) begin
      w_bx_nxt  = c_BALL_X0;
      w_by_nxt  = c_BALL_Y0;
      w_dxn_nxt = 1'b1;
      if (r_score_r == 4'd9) begin
        w_sl_nxt = 4'd0;
        w_sr_nxt = 4'd0;
      end else begin
        w_sr_nxt = r_score_r + 4'd1;
      end
    end else if (w_pt_l) begin
      w_bx_nxt  = c_BALL_X0;
      w_by_nxt  = c_BALL_Y0;
      w_dxn_nxt = 1'b0;
      if (r_score_l == 4'd9) begin
        w_sl_nxt = 4'd0;
        w_sr_nxt = 4'd0;
      end else begin
        w_sl_nxt = r_score_l + 4'd1;
      end
    end

    // Paddles aim to centre themselves on the ball (64/2 - 8/2 = 28)
    w_tgt    = signed'({2'b00, r_ball_y}) - 12'sd28;
    w_pl_nxt = ai_step(r_pl_y, w_tgt);
    w_pr_nxt = ai_step(r_pr_y, w_tgt);
  end

  // Game state register, loaded once per frame
  always_ff @(posedge clk_i) begin
    if (!rst_n_i) begin
      r_ball_x  <= c_BALL_X0;
      r_ball_y  <= c_BALL_Y0;
      r_dx_neg  <= 1'b0;
      r_dy_neg  <= 1'b0;
      r_pl_y    <= c_PAD_Y0;
      r_pr_y    <= c_PAD_Y0;
      r_score_l <= 4'd0;
      r_score_r <= 4'd0;
    end else if (w_frame) begin
      r_ball_x  <= w_bx_nxt;
      r_ball_y  <= w_by_nxt;
      r_dx_neg  <= w_dxn_nxt;
      r_dy_neg  <= w_dyn_nxt;
      r_pl_y    <= w_pl_nxt;
      r_pr_y    <= w_pr_nxt;
      r_score_l <= w_sl_nxt;
      r_score_r <= w_sr_nxt;
    end
  end

  // Decode syncs and pixel colour from the current raster position
  always_comb begin
    w_vis  = (r_hcnt < c_H_VIS) && (r_vcnt < c_V_VIS);
    w_ball = (r_hcnt >= r_ball_x) && (r_hcnt < r_ball_x + c_BALL_SZ) &&
             (r_vcnt >= r_ball_y) && (r_vcnt < r_ball_y + c_BALL_SZ);
    w_pad  = ((r_hcnt >= c_PL_X) && (r_hcnt < c_PL_X + c_PAD_W) &&
              (r_vcnt >= r_pl_y) && (r_vcnt < r_pl_y + c_PAD_H)) ||
             ((r_hcnt >= c_PR_X) && (r_hcnt < c_PR_X + c_PAD_W) &&
              (r_vcnt >= r_pr_y) && (r_vcnt < r_pr_y + c_PAD_H));
    w_mid  = (r_hcnt >= 10'd318) && (r_hcnt <= 10'd321) && !r_vcnt[4];
    w_rgb  = 12'h000;
    if (w_vis) begin
      if (w_ball || w_pad)
        w_rgb = 12'hFFF;
      else if (w_mid)
        w_rgb = 12'h888;
    end
    w_hs = !((r_hcnt >= c_HS_BEG) && (r_hcnt <= c_HS_END));
    w_vs = !((r_vcnt >= c_VS_BEG) && (r_vcnt <= c_VS_END));
  end

  // Output register keeps syncs and colour aligned with one clk of latency
  always_ff @(posedge clk_i) begin
    if (!rst_n_i) begin
      vga_hs_o <= 1'b1;
      vga_vs_o <= 1'b1;
      vga_r_o  <= 4'h0;
      vga_g_o  <= 4'h0;
      vga_b_o  <= 4'h0;
    end else begin
      vga_hs_o <= w_hs;
      vga_vs_o <= w_vs;
      vga_r_o  <= w_rgb[11:8];
      vga_g_o  <= w_rgb[7:4];
      vga_b_o  <= w_rgb[3:0];
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_board_top.sv
`default_nettype none
// ============================================================================
// Module   : tb_board_top
// Purpose  : Directed self-checking bench for board_top: raster timing table,
//            free-running sync cadence, mid-line reset, game next-state table
//            and full-line pixel scans at selected rows.
// Revision : 1.0 - initial release
// ============================================================================
module tb_board_top;

  logic       clk_i = 1'b0;
  logic       rst_n_i = 1'b0;
  logic       vga_hs_o;
  logic       vga_vs_o;
  logic [3:0] vga_r_o;
  logic [3:0] vga_g_o;
  logic [3:0] vga_b_o;

  int total = 0;
  int bad   = 0;
  int ecnt  = 0;   // edges since reset release

  // Values driven onto forced DUT state
  logic [9:0] f_bx, f_by, f_pl, f_pr, f_v;
  logic       f_dxn, f_dyn;
  logic [3:0] f_sl, f_sr;

  board_top dut (
    .clk_i   (clk_i),
    .rst_n_i (rst_n_i),
    .vga_hs_o(vga_hs_o),
    .vga_vs_o(vga_vs_o),
    .vga_r_o (vga_r_o),
    .vga_g_o (vga_g_o),
    .vga_b_o (vga_b_o)
  );

  always #10 clk_i = ~clk_i;

  typedef struct {
    int         e;
    int         hs;
    int         vs;
    logic [11:0] rgb;
  } tvec_t;

  typedef struct {
    int bx, by, dxn, dyn, pl, pr, sl, sr;
    int ebx, eby, edxn, edyn, epl, epr, esl, esr;
  } gvec_t;

  tvec_t tv[16];
  gvec_t gv[14];

  task automatic tick();
    @(posedge clk_i);
    #1;
    if (rst_n_i) ecnt++;
  endtask

  task automatic do_reset(input int n);
    rst_n_i = 1'b0;
    repeat (n) tick();
    rst_n_i = 1'b1;
    ecnt = 0;
  endtask

  task automatic run_to(input int e);
    while (ecnt < e) tick();
  endtask

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [13:0] outs();
    return {vga_hs_o, vga_vs_o, vga_r_o, vga_g_o, vga_b_o};
  endfunction

  // Reference picture with the reset-time ball and paddle positions
  function automatic logic [13:0] model_px(input int h, input int v);
    logic        hs, vs, on;
    logic [11:0] rgb;
    hs  = !(h >= 656 && h <= 751);
    vs  = !(v >= 490 && v <= 491);
    rgb = 12'h000;
    if (h < 640 && v < 480) begin
      on = (h >= 316 && h <= 323 && v >= 236 && v <= 243) ||
           (((h >= 16 && h <= 23) || (h >= 616 && h <= 623)) && v >= 208 && v <= 271);
      if (on)
        rgb = 12'hFFF;
      else if (h >= 318 && h <= 321 && ((v / 16) % 2) == 0)
        rgb = 12'h888;
    end
    return {hs, vs, rgb};
  endfunction

  task automatic scan_row(input int v);
    int          nb;
    int          fh;
    int          h;
    logic [13:0] e;
    nb = 0;
    fh = -1;
    rst_n_i = 1'b0;
    f_v = 10'(v);
    force dut.r_vcnt = f_v;
    tick();
    tick();
    rst_n_i = 1'b1;
    ecnt = 0;
    for (int k = 0; k < 1600; k++) begin
      tick();
      h = ((ecnt - 1) / 2) % 800;
      e = model_px(h, v);
      if (outs() !== e) begin
        nb++;
        if (fh < 0) fh = h;
      end
    end
    chk($sformatf("row%0d_pixels(first_bad_h=%0d)", v, fh), nb, 0);
  endtask

  initial begin
    int          prev_hs;
    int          nfall;
    int          last_fall;
    int          vslow;
    int          rows[10];

    // Raster checkpoints: edge number after release, hs, vs, colour
    tv[0]  = '{1,     1, 1, 12'h000};
    tv[1]  = '{636,   1, 1, 12'h000};
    tv[2]  = '{637,   1, 1, 12'h888};
    tv[3]  = '{644,   1, 1, 12'h888};
    tv[4]  = '{645,   1, 1, 12'h000};
    tv[5]  = '{1279,  1, 1, 12'h000};
    tv[6]  = '{1281,  1, 1, 12'h000};
    tv[7]  = '{1312,  1, 1, 12'h000};
    tv[8]  = '{1313,  0, 1, 12'h000};
    tv[9]  = '{1504,  0, 1, 12'h000};
    tv[10] = '{1505,  1, 1, 12'h000};
    tv[11] = '{1601,  1, 1, 12'h000};
    tv[12] = '{2237,  1, 1, 12'h888};
    tv[13] = '{24637, 1, 1, 12'h888};
    tv[14] = '{26237, 1, 1, 12'h000};
    tv[15] = '{26913, 0, 1, 12'h000};

    // Game next-state: {bx,by,dxn,dyn,pl,pr,sl,sr} -> expected next values
    gv[0]  = '{316,  4,0,1, 208,208,0,0,  318,  2,0,1, 206,206,0,0};
    gv[1]  = '{316,  1,0,1,   0,  0,0,0,  318,  0,0,0,   0,  0,0,0};
    gv[2]  = '{316,  2,0,1, 100,416,0,0,  318,  0,0,1,  98,414,0,0};
    gv[3]  = '{316,471,0,0, 416,416,0,0,  318,472,0,1, 416,416,0,0};
    gv[4]  = '{316,470,1,0, 300,400,0,0,  314,472,1,0, 302,402,0,0};
    gv[5]  = '{316,238,0,0, 208,212,0,0,  318,240,0,0, 208,212,0,0};
    gv[6]  = '{316,238,1,1, 207,213,0,0,  314,236,1,1, 209,211,0,0};
    gv[7]  = '{ 25,200,1,0, 180,208,0,0,   23,202,0,0, 178,206,0,0};
    gv[8]  = '{ 25,300,1,0, 180,208,0,0,   23,302,1,0, 182,210,0,0};
    gv[9]  = '{607,200,0,1, 208,150,0,0,  609,198,1,1, 206,152,0,0};
    gv[10] = '{  2,100,1,0, 208,208,5,3,  316,236,1,0, 206,206,5,4};
    gv[11] = '{630,100,0,0, 208,208,4,2,  316,236,0,0, 206,206,5,2};
    gv[12] = '{630,100,0,0, 208,208,9,7,  316,236,0,0, 206,206,0,0};
    gv[13] = '{  2,100,1,0, 208,208,3,9,  316,236,1,0, 206,206,0,0};

    rows = '{207, 236, 243, 244, 271, 272, 489, 490, 491, 492};

    // Reset held for two edges
    rst_n_i = 1'b0;
    tick();
    tick();
    chk("reset_outputs", outs(), {1'b1, 1'b1, 12'h000});
    chk("reset_counters", {dut.r_pix_en, dut.r_hcnt, dut.r_vcnt}, 21'd0);
    chk("reset_game", {dut.r_ball_x, dut.r_ball_y, dut.r_dx_neg, dut.r_dy_neg,
                       dut.r_pl_y, dut.r_pr_y, dut.r_score_l, dut.r_score_r},
        {10'd316, 10'd236, 1'b0, 1'b0, 10'd208, 10'd208, 4'd0, 4'd0});
    rst_n_i = 1'b1;
    ecnt = 0;

    // Raster checkpoint table
    for (int i = 0; i < 16; i++) begin
      run_to(tv[i].e);
      chk($sformatf("raster_e%0d", tv[i].e), outs(),
          {1'(tv[i].hs), 1'(tv[i].vs), tv[i].rgb});
    end

    // Free run: hs cadence and vs inactive across 10000 edges
    do_reset(2);
    prev_hs = 1;
    nfall = 0;
    last_fall = 0;
    vslow = 0;
    for (int k = 0; k < 10000; k++) begin
      tick();
      if (vga_vs_o !== 1'b1) vslow++;
      if (prev_hs == 1 && vga_hs_o === 1'b0) begin
        if (nfall == 0)
          chk("hs_first_fall_edge", ecnt, 1313);
        else
          chk("hs_period", ecnt - last_fall, 1600);
        last_fall = ecnt;
        nfall++;
      end
      if (prev_hs == 0 && vga_hs_o === 1'b1)
        chk("hs_low_width", ecnt - last_fall, 192);
      prev_hs = (vga_hs_o === 1'b1) ? 1 : 0;
    end
    chk("hs_fall_count", nfall, 6);
    chk("vs_low_cycles_freerun", vslow, 0);

    // Reset asserted mid-line at hcnt=700
    do_reset(2);
    run_to(1401);
    chk("hcnt_before_midline_reset", dut.r_hcnt, 700);
    chk("hs_low_before_midline_reset", vga_hs_o, 0);
    rst_n_i = 1'b0;
    tick();
    chk("midline_reset_outputs", outs(), {1'b1, 1'b1, 12'h000});
    chk("midline_reset_counters", {dut.r_pix_en, dut.r_hcnt, dut.r_vcnt}, 21'd0);
    rst_n_i = 1'b1;
    ecnt = 0;
    run_to(1312);
    chk("restart_hs_high_e1312", vga_hs_o, 1);
    tick();
    chk("restart_hs_low_e1313", vga_hs_o, 0);

    // Game next-state table on forced state (no frame update while vcnt is small)
    do_reset(2);
    tick();
    for (int i = 0; i < 14; i++) begin
      f_bx  = 10'(gv[i].bx);
      f_by  = 10'(gv[i].by);
      f_dxn = 1'(gv[i].dxn);
      f_dyn = 1'(gv[i].dyn);
      f_pl  = 10'(gv[i].pl);
      f_pr  = 10'(gv[i].pr);
      f_sl  = 4'(gv[i].sl);
      f_sr  = 4'(gv[i].sr);
      force dut.r_ball_x  = f_bx;
      force dut.r_ball_y  = f_by;
      force dut.r_dx_neg  = f_dxn;
      force dut.r_dy_neg  = f_dyn;
      force dut.r_pl_y    = f_pl;
      force dut.r_pr_y    = f_pr;
      force dut.r_score_l = f_sl;
      force dut.r_score_r = f_sr;
      #1;
      chk($sformatf("game_vec%0d", i),
          {dut.w_bx_nxt, dut.w_by_nxt, dut.w_dxn_nxt, dut.w_dyn_nxt,
           dut.w_pl_nxt, dut.w_pr_nxt, dut.w_sl_nxt, dut.w_sr_nxt},
          {10'(gv[i].ebx), 10'(gv[i].eby), 1'(gv[i].edxn), 1'(gv[i].edyn),
           10'(gv[i].epl), 10'(gv[i].epr), 4'(gv[i].esl), 4'(gv[i].esr)});
    end
    release dut.r_ball_x;
    release dut.r_ball_y;
    release dut.r_dx_neg;
    release dut.r_dy_neg;
    release dut.r_pl_y;
    release dut.r_pr_y;
    release dut.r_score_l;
    release dut.r_score_r;
    do_reset(2);

    // Full-line scans at rows through ball, paddles and vertical sync
    for (int i = 0; i < 10; i++) scan_row(rows[i]);
    release dut.r_vcnt;
    do_reset(2);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
